// File: rtl/chip_select_pkg.sv
// Shared state encoding, default sizes and chip-enable decoder for chip_select_arbiter.
package chip_select_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 8;
   localparam int unsigned DEFAULT_NCE    = 2;
   localparam int unsigned MAX_ADDR_W     = 32;
   localparam int unsigned MAX_NCE        = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } cs_state_t;

   // index width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cs_idx_w(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

   // one-hot chip enable for addr; all-zero when addr does not select a chip
   function automatic logic [MAX_NCE-1:0] cs_decode(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int unsigned nce);
      logic [MAX_NCE-1:0] ce;
      ce = '0;
      for (int unsigned i = 0; i < MAX_NCE; i++) begin
         if ((addr == MAX_ADDR_W'(i)) && (i < nce))
            ce = MAX_NCE'(1) << i;
      end
      return ce;
   endfunction

endpackage

// File: rtl/chip_select_arbiter_rr_arbiter.sv
// Combinational requester selection: round-robin from ptr, or lowest index when
// CHIP_SELECT_ARBITER_FIXED_PRIO_EN is defined (ptr port then absent).
module rr_arbiter
   import chip_select_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]               req,
`ifndef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
   input  logic [cs_idx_w(NREQ)-1:0]     ptr,
`endif
   output logic [NREQ-1:0]               gnt,
   output logic [cs_idx_w(NREQ)-1:0]     idx
);

   localparam int unsigned IDX_W = cs_idx_w(NREQ);

   logic        found;
   int unsigned pos;

   // first set request in search order wins
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
         pos = k;
`else
         pos = (32'(ptr) + k) % NREQ;
`endif
         if (!found && req[IDX_W'(pos)]) begin
            found               = 1'b1;
            gnt[IDX_W'(pos)]    = 1'b1;
            idx                 = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/chip_select_arbiter.sv
// Shares one chip-select address bus among NREQ requesters and sequences each access.
// Define CHIP_SELECT_ARBITER_FIXED_PRIO_EN for fixed (lowest-index) priority instead of round-robin.
module chip_select_arbiter
   import chip_select_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
   parameter int unsigned NCE      = DEFAULT_NCE,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NREQ-1:0]          REQ,
   input  logic [NREQ*ADDR_W-1:0]   ADDR_IN,
   output logic [NREQ-1:0]          GNT,
   output logic [NREQ-1:0]          ACK,
   output logic [NREQ-1:0]          ERR,
   output logic [ADDR_W-1:0]        ADDRESS,
   output logic [NCE-1:0]           CE,
   output logic                     BUSY
);

   localparam int unsigned IDX_W = cs_idx_w(NREQ);
   localparam int unsigned CNT_W = cs_idx_w(WAIT_CYC);

   if (WAIT_CYC == 0) begin : g_bad_wait
      $error("chip_select_arbiter: WAIT_CYC must be at least 1");
   end
   if (NREQ < 2) begin : g_bad_nreq
      $error("chip_select_arbiter: NREQ must be at least 2");
   end
   if ((ADDR_W > MAX_ADDR_W) || (NCE > MAX_NCE) || (NCE == 0)) begin : g_bad_size
      $error("chip_select_arbiter: ADDR_W or NCE out of supported range");
   end

   cs_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic [NREQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic [ADDR_W-1:0]  addr_arr [NREQ];
   logic [ADDR_W-1:0]  win_addr;
   logic [NCE-1:0]     ce_dec;
`ifndef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
   logic [IDX_W-1:0]   ptr;
`endif

   for (genvar i = 0; i < NREQ; i++) begin : g_addr
      assign addr_arr[i] = ADDR_IN[i*ADDR_W +: ADDR_W];
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (REQ),
`ifndef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
      .ptr (ptr),
`endif
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign win_addr = addr_arr[arb_idx];
   assign ce_dec   = NCE'(cs_decode(MAX_ADDR_W'(win_addr), NCE));

   // access sequencer; every output is a register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         GNT     <= '0;
         ACK     <= '0;
         ERR     <= '0;
         ADDRESS <= '0;
         CE      <= '0;
         BUSY    <= 1'b0;
`ifndef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
         ptr     <= '0;
`endif
      end else begin
         ACK <= '0;
         ERR <= '0;
         case (state)
            IDLE: begin
               if (|REQ) begin
                  GNT     <= arb_gnt;
                  ADDRESS <= win_addr;
                  BUSY    <= 1'b1;
`ifndef CHIP_SELECT_ARBITER_FIXED_PRIO_EN
                  ptr     <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
                  if (|ce_dec) begin
                     CE    <= ce_dec;
                     cnt   <= CNT_W'(WAIT_CYC - 1);
                     state <= ACCESS;
                  end else begin
                     ERR   <= arb_gnt;
                     state <= DONE;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  CE    <= '0;
                  ACK   <= GNT;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               GNT     <= '0;
               ADDRESS <= '0;
               BUSY    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
